// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single-port synchronous memory: CPU has fixed priority,
// DMA is forced through after MAX_WAIT consecutive lost contests.
module mem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk_50MHz,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_DMA} owner_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    owner_t        owner_reg;
    logic          rd_pend_reg;
    logic [3:0]    wait_cnt_reg;
    logic [3:0]    wait_cnt_next;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_data_reg;
    logic          mem_wren_reg;
    logic [1:0]    rvalid_reg;
    logic          dma_due;

    assign dma_due = (wait_cnt_reg == WAIT_LIMIT);
    assign cpu_gnt = !reset && cpu_req && !(dma_req && dma_due);
    assign dma_gnt = !reset && dma_req && (!cpu_req || dma_due);

    // Counter only advances while the DMA is actively losing a contest.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!cpu_req && !dma_req) begin
            wait_cnt_next = wait_cnt_reg;
        end else if (!dma_req || dma_gnt) begin
            wait_cnt_next = 4'd0;
        end else begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            mem_wren_reg <= 1'b0;
            owner_reg    <= OWN_IDLE;
            rd_pend_reg  <= 1'b0;
            wait_cnt_reg <= 4'd0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            if (cpu_gnt) begin
                mem_addr_reg <= cpu_addr;
                mem_data_reg <= cpu_wdata;
                mem_wren_reg <= cpu_we;
                owner_reg    <= OWN_CPU;
                rd_pend_reg  <= !cpu_we;
            end else if (dma_gnt) begin
                mem_addr_reg <= dma_addr;
                mem_data_reg <= dma_wdata;
                mem_wren_reg <= dma_we;
                owner_reg    <= OWN_DMA;
                rd_pend_reg  <= !dma_we;
            end else begin
                mem_wren_reg <= 1'b0;
                owner_reg    <= OWN_IDLE;
                rd_pend_reg  <= 1'b0;
            end
        end
    end

    // Read-valid trails the address stage by one cycle, matching mem_q latency.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
            localparam owner_t PORT_OWNER = (gi == 0) ? OWN_CPU : OWN_DMA;
            always_ff @(posedge clk_50MHz) begin
                if (reset) begin
                    rvalid_reg[gi] <= 1'b0;
                end else begin
                    rvalid_reg[gi] <= rd_pend_reg && (owner_reg == PORT_OWNER);
                end
            end
        end
    endgenerate

    assign cpu_rvalid = rvalid_reg[0];
    assign dma_rvalid = rvalid_reg[1];
    assign rdata      = mem_q;
    assign mem_addr   = mem_addr_reg;
    assign mem_data   = mem_data_reg;
    assign mem_wren   = mem_wren_reg;

endmodule
